// File: rtl/cacheline_burst_responder_pkg.sv
// Shared types and constants for the cacheline <-> 64-bit burst responder.
package cacheline_burst_responder_pkg;

  localparam int s_offset    = 5;
  localparam int s_line      = 8 * (2 ** s_offset);
  localparam int s_beat      = 64;
  localparam int burst_beats = s_line / s_beat;

  typedef logic [31:0]                      rv32i_word;
  typedef logic [s_line-1:0]                cacheline_t;
  typedef logic [s_beat-1:0]                beat_t;
  typedef logic [$clog2(burst_beats)-1:0]   beat_cnt_t;

  function automatic rv32i_word line_align(input rv32i_word addr);
    return {addr[31:s_offset], {s_offset{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_burst_responder.sv
// Converts a cache line read/write into a 4-beat 64-bit memory burst and
// returns a single-cycle completion pulse to the cache.
module cacheline_burst_responder
  import cacheline_burst_responder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [31:0]  burst_address,
  output logic         burst_read,
  output logic         burst_write,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp
);

  typedef enum logic [1:0] {
    IDLE,
    READ_BURST,
    WRITE_BURST,
    DONE
  } state_t;

  state_t     state;
  beat_cnt_t  cnt;
  rv32i_word  addr_q;
  cacheline_t wline_q;

  localparam beat_cnt_t last_beat = beat_cnt_t'(burst_beats - 1);

  // Address is stored already line-aligned; the write beat is a pure slice
  // of the latched line so it follows cnt with no extra register stage.
  assign burst_address = addr_q;
  assign burst_wdata   = wline_q[s_beat*cnt +: s_beat];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wline_q     <= '0;
      pmem_rdata  <= '0;
      pmem_resp   <= 1'b0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pmem_write) begin
            addr_q      <= line_align(pmem_address);
            wline_q     <= pmem_wdata;
            burst_write <= 1'b1;
            state       <= WRITE_BURST;
          end else if (pmem_read) begin
            addr_q     <= line_align(pmem_address);
            burst_read <= 1'b1;
            state      <= READ_BURST;
          end
        end
        READ_BURST: begin
          if (burst_resp) begin
            pmem_rdata[s_beat*cnt +: s_beat] <= burst_rdata;
            cnt <= cnt + beat_cnt_t'(1);
            if (cnt == last_beat) begin
              burst_read <= 1'b0;
              pmem_resp  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        WRITE_BURST: begin
          if (burst_resp) begin
            cnt <= cnt + beat_cnt_t'(1);
            if (cnt == last_beat) begin
              burst_write <= 1'b0;
              pmem_resp   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_responder.sv
// Scoreboard bench for cacheline_burst_responder with a cycle-driven memory model.
module tb_cacheline_burst_responder;
  import cacheline_burst_responder_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int vectors     = 0;
  int miscompares = 0;
  logic [255:0] exp_q[$];
  logic [255:0] last_rd_line;

  cacheline_burst_responder dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // One cacheline transaction. Returns after the negedge of the pmem_resp
  // cycle so the caller can either present a back-to-back request or idle.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [255:0] line, input int stall_beat,
                         input int stall_n, input int exp_lat, input string name);
    int beat, stalls, wr_cycles, rd_cycles;
    bit done;
    logic [255:0] exp;
    logic [31:0] exp_addr;
    beat = 0; stalls = 0; wr_cycles = 0; rd_cycles = 0; done = 0;
    exp_addr = addr & 32'hFFFF_FFE0;
    @(posedge clk); #1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wr ? line : rand_line();
    burst_resp   = 1'b0;
    burst_rdata  = {$urandom, $urandom};
    exp_q.push_back(line);
    @(negedge clk);
    vectors++;
    if ({pmem_resp, burst_read, burst_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s idle_cycle: resp/rd/wr=%b required 000", name, {pmem_resp, burst_read, burst_write});
    end
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      if (beat < 4 && beat == stall_beat && stalls < stall_n) begin
        burst_resp  = 1'b0;
        burst_rdata = {$urandom, $urandom};
        stalls++;
      end else if (beat < 4) begin
        burst_resp  = 1'b1;
        burst_rdata = wr ? {$urandom, $urandom} : line[64*beat +: 64];
      end else begin
        burst_resp  = 1'b0;
      end
      @(negedge clk);
      if (pmem_resp) begin
        done = 1;
        burst_resp = 1'b0;
        vectors++;
        if (c != exp_lat) begin
          miscompares++;
          $display("FAIL %s latency: got %0d required %0d", name, c, exp_lat);
        end
        vectors++;
        if ({burst_read, burst_write} !== 2'b00) begin
          miscompares++;
          $display("FAIL %s done_req: rd/wr=%b required 00", name, {burst_read, burst_write});
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s scoreboard: got empty queue required 1 entry", name);
        end else begin
          exp = exp_q.pop_front();
          if (!wr) last_rd_line = exp;
          if (pmem_rdata !== last_rd_line) begin
            miscompares++;
            $display("FAIL %s pmem_rdata: got %h required %h", name, pmem_rdata, last_rd_line);
          end
        end
        vectors++;
        if (wr_cycles != (wr ? 4 + stall_n : 0) || rd_cycles != (wr ? 0 : 4 + stall_n)) begin
          miscompares++;
          $display("FAIL %s req_cycles: wr=%0d rd=%0d required wr=%0d rd=%0d", name,
                   wr_cycles, rd_cycles, wr ? 4 + stall_n : 0, wr ? 0 : 4 + stall_n);
        end
      end else begin
        if (burst_write === 1'b1) wr_cycles++;
        if (burst_read === 1'b1) rd_cycles++;
        vectors++;
        if (burst_address !== exp_addr || burst_read !== !wr || burst_write !== wr) begin
          miscompares++;
          $display("FAIL %s burst_req c%0d: addr=%h rd=%b wr=%b required addr=%h rd=%b wr=%b",
                   name, c, burst_address, burst_read, burst_write, exp_addr, !wr, wr);
        end
        if (wr && beat < 4) begin
          vectors++;
          if (burst_wdata !== line[64*beat +: 64]) begin
            miscompares++;
            $display("FAIL %s burst_wdata beat%0d: got %h required %h", name, beat,
                     burst_wdata, line[64*beat +: 64]);
          end
        end
        if (burst_resp) beat++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no pmem_resp within 40 cycles", name);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      @(negedge clk);
      vectors++;
      if ({pmem_resp, burst_read, burst_write} !== 3'b000 || pmem_rdata !== last_rd_line) begin
        miscompares++;
        $display("FAIL idle: resp/rd/wr=%b rdata=%h required 000 rdata=%h",
                 {pmem_resp, burst_read, burst_write}, pmem_rdata, last_rd_line);
      end
    end
    @(posedge clk); #1;
    burst_resp = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({pmem_resp, burst_read, burst_write} !== 3'b000 || burst_address !== 32'h0 ||
        burst_wdata !== 64'h0 || pmem_rdata !== 256'h0) begin
      miscompares++;
      $display("FAIL %s: resp/rd/wr=%b addr=%h wdata=%h rdata=%h required all 0", name,
               {pmem_resp, burst_read, burst_write}, burst_address, burst_wdata, pmem_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    burst_resp = 1'b0; burst_rdata = '0;
    last_rd_line = '0;
    #3;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
  endtask

  task automatic test_read_zero_wait();
    run_txn(1'b0, 1'b1, 32'h0000_1234,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            9, 0, 5, "read_zero_wait");
    idle(2);
  endtask

  task automatic test_write();
    run_txn(1'b1, 1'b0, 32'h8000_0047,
            {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
            9, 0, 5, "write");
    idle(2);
  endtask

  task automatic test_wait_states();
    run_txn(1'b0, 1'b1, 32'h0000_2468, rand_line(), 2, 2, 7, "read_wait");
    idle(1);
    run_txn(1'b1, 1'b0, 32'h0000_3579, rand_line(), 2, 2, 7, "write_wait");
    idle(1);
  endtask

  task automatic test_simultaneous();
    run_txn(1'b1, 1'b1, 32'hFFFF_FFFF, rand_line(), 9, 0, 5, "rd_wr_both");
    idle(1);
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    pmem_read = 1'b1; pmem_address = 32'h0000_5A5F; burst_resp = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
    #2 rst = 1'b0;
    #1 check_all_zero("reset_async");
    pmem_read = 1'b0; burst_resp = 1'b0;
    last_rd_line = '0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    @(posedge clk); #1 rst = 1'b1;
    idle(1);
    run_txn(1'b0, 1'b1, 32'h0000_0C00, rand_line(), 9, 0, 5, "read_after_reset");
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 1'b1, 32'h0001_0010, rand_line(), 9, 0, 5, "b2b_read");
    run_txn(1'b1, 1'b0, 32'h0002_0020, rand_line(), 9, 0, 5, "b2b_write");
    run_txn(1'b0, 1'b1, 32'h0003_0030, rand_line(), 1, 1, 6, "b2b_read2");
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int sb, sn;
      logic w;
      w  = 1'($urandom_range(0, 1));
      sb = $urandom_range(0, 3);
      sn = $urandom_range(0, 3);
      run_txn(w, !w, $urandom, rand_line(), sb, sn, 5 + sn, "random");
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write();
    test_wait_states();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_responder.md
# cacheline_burst_responder

Responder for the L1 caches' 256-bit cacheline port (pmem_address / pmem_read / pmem_write / pmem_rdata / pmem_wdata / pmem_resp). It sits between the instruction or data cache and main memory. Each cacheline read or write is converted into a 4-beat, 64-bit burst on the memory side. For reads it reassembles the line; for writes it serialises the line. It returns a single-cycle response to the cache.

## Interface
- s_offset, 5, line offset bits; line is 2**s_offset bytes (32)
- s_line, 256, line width in bits (8*2**s_offset)
- s_beat, 64, burst beat width in bits; beat count = s_line/s_beat = 4
- clk  input  1  clock, all state rising-edge
- rst  input  1  reset; asynchronous, active-low
- pmem_address  input  32  line address from cache
- pmem_read  input  1  line read request, held until pmem_resp
- pmem_write  input  1  line write request, held until pmem_resp
- pmem_wdata  input  256  write line
- pmem_rdata  output  256  read line
- pmem_resp  output  1  one-cycle completion pulse
- burst_address  output  32  line-aligned address to memory
- burst_read  output  1  memory read burst request
- burst_write  output  1  memory write burst request
- burst_wdata  output  64  current write beat
- burst_rdata  input  64  current read beat
- burst_resp  input  1  beat-valid / beat-accepted strobe from memory

## Operation
- States: IDLE, READ_BURST, WRITE_BURST, DONE.
- IDLE behaviour:
  - pmem_write high → latch address and pmem_wdata, go WRITE_BURST.
  - Else pmem_read high → latch address, go READ_BURST.
  - Write has priority if both are high.
- burst_address is the latched address with bits [s_offset-1:0] forced to 0.
- READ_BURST:
  - burst_read = 1.
  - Each cycle with burst_resp = 1, burst_rdata is written into line slice [64*cnt +: 64] and the 2-bit beat counter cnt increments.
  - On the beat with cnt = 3, go DONE.
- WRITE_BURST:
  - burst_write = 1 and burst_wdata = latched line slice [64*cnt +: 64], beat 0 = bits 63:0.
  - cnt advances on burst_resp; after beat 3, go DONE.
- burst_resp low stalls the burst: cnt, data and state hold, and the request stays asserted.
- cnt wraps 3→0 at burst end, so it is 0 whenever the block enters IDLE.
- DONE:
  - pmem_resp = 1 for exactly one cycle, then go IDLE.
  - pmem_rdata is the assembled line, held stable until the next read burst starts overwriting it.
- burst_resp seen in IDLE or DONE is ignored.
- Requester contract: pmem_read and pmem_write are held constant until pmem_resp, then dropped or changed on the following edge. The block does not re-sample mid-burst; request changes during a burst are ignored.

## Timing
- Reset (rst low, asynchronous): state IDLE, cnt 0, pmem_resp 0, burst_read 0, burst_write 0, burst_address 0, burst_wdata 0, pmem_rdata 0.
- Reset mid-burst aborts the burst immediately; no pmem_resp is issued.
- burst_read and burst_write are registered state decodes: asserted the cycle after acceptance, deasserted in DONE.
- With zero-wait memory (burst_resp high every cycle), total latency is 6 cycles:
  - cycle 0: request seen in IDLE
  - cycles 1–4: beats 0–3
  - cycle 5: pmem_resp
- Each cycle of burst_resp low adds one cycle.
- A back-to-back request sampled in the IDLE cycle after DONE starts the next burst with no dead cycle beyond that IDLE.
- pmem_rdata changes only on edges where a read beat is captured.

## Structure
- rv32i_types: rv32i_word is used for the addresses.
- Shared package, add:
  - line typedef cacheline_t (logic [255:0]) and beat typedef beat_t (logic [63:0]).
  - The burst-beat-count constant.
- State enum is local to the module.
- Single module; no sub-module needed. Counter and line register are inline.

## Test plan
- Read, zero-wait:
  - Stimulus: pmem_read with address 0x0000_1234; beats 0x1111…, 0x2222…, 0x3333…, 0x4444….
  - Response: burst_address = 0x0000_1220; pmem_resp in cycle 5; pmem_rdata = {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Write:
  - Stimulus: pmem_wdata = 256'h…DDDD_CCCC_BBBB_AAAA (64-bit slices).
  - Response: burst_wdata shows slices 0→3 in order across beats; burst_write high for 4 cycles; single pmem_resp.
- Wait states:
  - Stimulus: burst_resp low for 2 cycles before beat 2.
  - Response: cnt and outputs hold; pmem_resp arrives in cycle 7; data still correct.
- Simultaneous read and write in IDLE → WRITE_BURST taken, burst_read never asserted.
- Reset:
  - Stimulus: rst low during beat 2 of a read.
  - Response: all outputs 0 asynchronously; no pmem_resp; a following read completes normally with cnt starting at 0.
- Back-to-back: read then write issued the cycle after pmem_resp → second burst starts one cycle later, both complete with correct data.
